// File: rtl/pipe_skid_stage.sv
// Elastic pipeline stage: valid/ready handshake with a 2-entry skid buffer,
// flush, a registered reset copy and a saturating stall counter.
module pipe_skid_stage #(
  parameter int                 DATA_W    = 64,
  parameter logic [DATA_W-1:0]  RESET_VAL = '0,
  parameter int                 CNT_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_nop,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_nop,
  output logic              reset_out,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {EMPTY = 2'd0, BUSY = 2'd1, FULL = 2'd2} state_e;

  state_e             state_q, state_d;
  logic [DATA_W-1:0]  main_data_q, main_data_d, skid_data_q, skid_data_d;
  logic               main_nop_q, main_nop_d, skid_nop_q, skid_nop_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic               reset_out_q;
  logic               in_fire, out_fire;

  // in_ready decodes the state register only, so it never depends on out_ready.
  assign in_ready  = (state_q != FULL) && !reset;
  assign out_valid = (state_q != EMPTY);
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  assign out_data  = main_data_q;
  assign out_nop   = main_nop_q;
  assign reset_out = reset_out_q;
  assign stall_cnt = stall_cnt_q;

  always_comb begin
    occupancy = 2'd0;
    case (state_q)
      BUSY:    occupancy = 2'd1;
      FULL:    occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    main_nop_d  = main_nop_q;
    skid_data_d = skid_data_q;
    skid_nop_d  = skid_nop_q;
    stall_cnt_d = stall_cnt_q;

    case (state_q)
      EMPTY: if (in_fire) begin
        state_d     = BUSY;
        main_data_d = in_data;
        main_nop_d  = in_nop;
      end
      BUSY: begin
        if (in_fire && out_fire) begin
          main_data_d = in_data;
          main_nop_d  = in_nop;
        end else if (in_fire) begin
          state_d     = FULL;
          skid_data_d = in_data;
          skid_nop_d  = in_nop;
        end else if (out_fire) begin
          state_d = EMPTY;
        end
      end
      FULL: if (out_fire) begin
        state_d     = BUSY;
        main_data_d = skid_data_q;
        main_nop_d  = skid_nop_q;
      end
      default: state_d = EMPTY;
    endcase

    // Squash overrides everything; an out_fire this cycle still counts downstream.
    if (flush) begin
      state_d     = EMPTY;
      main_data_d = RESET_VAL;
      main_nop_d  = 1'b0;
      skid_data_d = RESET_VAL;
      skid_nop_d  = 1'b0;
    end

    if (out_valid && !out_ready && (stall_cnt_q != {CNT_W{1'b1}}))
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    reset_out_q <= reset;
    if (reset) begin
      state_q     <= EMPTY;
      main_data_q <= RESET_VAL;
      main_nop_q  <= 1'b0;
      skid_data_q <= RESET_VAL;
      skid_nop_q  <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      main_data_q <= main_data_d;
      main_nop_q  <= main_nop_d;
      skid_data_q <= skid_data_d;
      skid_nop_q  <= skid_nop_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Bench for pipe_skid_stage: directed steps then random traffic, all checked
// against a FIFO-queue reference model of the stage.
module tb_pipe_skid_stage;
  localparam int             DW = 32;
  localparam logic [DW-1:0]  RV = 32'hDEAD_BEEF;

  logic          clk = 1'b0;
  logic          reset, flush, in_valid, in_nop, out_ready;
  logic [DW-1:0] in_data;
  logic          in_ready, out_valid, out_nop, reset_out;
  logic [DW-1:0] out_data;
  logic [1:0]    occupancy;
  logic [15:0]   stall_cnt;
  logic          s_in_ready, s_out_valid, s_out_nop, s_reset_out;
  logic [DW-1:0] s_out_data;
  logic [1:0]    s_occupancy;
  logic [1:0]    s_stall_cnt;

  pipe_skid_stage #(.DATA_W(DW), .RESET_VAL(RV), .CNT_W(16)) u_dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_nop(in_nop), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_nop(out_nop), .reset_out(reset_out),
    .occupancy(occupancy), .stall_cnt(stall_cnt));

  // Narrow-counter copy on the same stimulus, for saturation.
  pipe_skid_stage #(.DATA_W(DW), .RESET_VAL(RV), .CNT_W(2)) u_sat (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_data(in_data), .in_nop(in_nop), .out_valid(s_out_valid), .out_ready(out_ready),
    .out_data(s_out_data), .out_nop(s_out_nop), .reset_out(s_reset_out),
    .occupancy(s_occupancy), .stall_cnt(s_stall_cnt));

  always #5 clk = ~clk;

  int n_cmp = 0, n_err = 0;

  // Model: the held beats are just a FIFO of {nop,data}; idle is what the
  // head register shows when nothing is held (last beat out, or RESET_VAL).
  logic [DW:0] q[$];
  logic [DW:0] idle;
  int          m_stall, m_sat;
  logic        m_rst_out;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [DW:0] head;
    head = (q.size() > 0) ? q[0] : idle;
    chk("in_ready",  64'(in_ready),  64'(!reset && q.size() < 2));
    chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
    chk("out_data",  64'(out_data),  64'(head[DW-1:0]));
    chk("out_nop",   64'(out_nop),   64'(head[DW]));
    chk("occupancy", 64'(occupancy), 64'(q.size()));
    chk("stall_cnt", 64'(stall_cnt), 64'(m_stall));
    chk("sat_cnt",   64'(s_stall_cnt), 64'(m_sat));
    chk("reset_out", 64'(reset_out), 64'(m_rst_out));
  endtask

  task automatic step();
    logic in_fire, out_fire;
    @(posedge clk);
    in_fire  = in_valid && !reset && (q.size() < 2);
    out_fire = (q.size() > 0) && out_ready;
    if (reset) begin
      q.delete();
      idle    = {1'b0, RV};
      m_stall = 0;
      m_sat   = 0;
    end else begin
      if (q.size() > 0 && !out_ready) begin
        if (m_stall < 65535) m_stall++;
        if (m_sat < 3) m_sat++;
      end
      if (out_fire) idle = q.pop_front();
      if (flush) begin
        q.delete();
        idle = {1'b0, RV};
      end else if (in_fire) begin
        q.push_back({in_nop, in_data});
      end
    end
    m_rst_out = reset;
    @(negedge clk);
    check_all();
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_nop = 1'b0;
    out_ready = 1'b0; in_data = '0;
    step(); step();
    reset = 1'b0;
    step();

    // 1: streaming at full rate, one clk latency
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_data = DW'(i); in_nop = i[0];
      step();
      chk("t1_data", 64'(out_data), 64'(i));
      chk("t1_occ",  64'(occupancy), 64'd1);
    end
    in_valid = 1'b0; in_nop = 1'b0;
    step();
    chk("t1_stall", 64'(stall_cnt), 64'd0);

    // 2: back-pressure fills the skid entry
    out_ready = 1'b0; in_valid = 1'b1;
    in_data = 32'hAAAA_0001; step();
    in_data = 32'hBBBB_0002; step();
    in_valid = 1'b0;
    chk("t2_occ",   64'(occupancy), 64'd2);
    chk("t2_rdy",   64'(in_ready),  64'd0);
    chk("t2_head",  64'(out_data),  64'h0000_0000_AAAA_0001);
    out_ready = 1'b1; step();
    chk("t2_second", 64'(out_data), 64'h0000_0000_BBBB_0002);
    chk("t2_rdy_back", 64'(in_ready), 64'd1);
    step();
    chk("t2_drained", 64'(out_valid), 64'd0);

    // 3: flush from FULL, and from BUSY with a beat handshaken in the flush cycle
    out_ready = 1'b0; in_valid = 1'b1;
    in_data = 32'h1111_1111; step();
    in_data = 32'h2222_2222; step();
    flush = 1'b1; in_data = 32'h3333_3333; step();
    flush = 1'b0; in_valid = 1'b0;
    chk("t3_valid", 64'(out_valid), 64'd0);
    chk("t3_occ",   64'(occupancy), 64'd0);
    chk("t3_data",  64'(out_data),  64'(RV));
    in_valid = 1'b1; in_data = 32'h4444_4444; step();
    flush = 1'b1; in_data = 32'h5555_5555; step();
    flush = 1'b0; in_valid = 1'b0;
    chk("t3_discard", 64'(occupancy), 64'd0);
    out_ready = 1'b1; step();
    chk("t3_nothing", 64'(out_valid), 64'd0);

    // 4: stall counting and saturation of the narrow counter
    reset = 1'b1; step(); reset = 1'b0;
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h0E0E_0E0E; step();
    in_valid = 1'b0;
    repeat (5) step();
    chk("t4_stall5", 64'(stall_cnt), 64'd5);
    repeat (5) step();
    chk("t4_stall10", 64'(stall_cnt), 64'd10);
    chk("t4_sat",     64'(s_stall_cnt), 64'd3);
    out_ready = 1'b1; step();

    // 5: reset while FULL
    out_ready = 1'b0; in_valid = 1'b1;
    in_data = 32'h6666_6666; step();
    in_data = 32'h7777_7777; step();
    in_valid = 1'b0;
    chk("t5_full", 64'(occupancy), 64'd2);
    reset = 1'b1; step();
    chk("t5_valid", 64'(out_valid), 64'd0);
    chk("t5_rdy",   64'(in_ready),  64'd0);
    chk("t5_rstout", 64'(reset_out), 64'd1);
    chk("t5_stall", 64'(stall_cnt), 64'd0);
    reset = 1'b0; step();
    chk("t5_rstout_low", 64'(reset_out), 64'd0);

    // 6: random traffic against the model
    for (int i = 0; i < 10000; i++) begin
      in_valid  = ($urandom_range(0, 99) < 60);
      out_ready = ($urandom_range(0, 99) < 55);
      flush     = ($urandom_range(0, 31) == 0);
      reset     = ($urandom_range(0, 499) == 0);
      in_nop    = $urandom_range(0, 1) == 1;
      in_data   = $urandom;
      step();
    end
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    step(); step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
